// File: rtl/fir_feeder.sv
// Coefficient/sample sequencer for the Fir filter: FIFO-buffered word stream, TAPS coefficients then samples.
// Optional FLUSH state (TAPS-1 zero samples after each frame) enabled by FIR_FEEDER_FLUSH_EN.
module fir_feeder #(
   parameter int DATA_WIDTH = 32,
   parameter int TAPS       = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_last,
   output logic                  s_ready,
   input  logic                  reload,
   input  logic                  stall,
   output logic                  fir_enable,
   output logic                  fir_control,
   output logic [DATA_WIDTH-1:0] fir_b,
   output logic [DATA_WIDTH-1:0] fir_x,
   output logic                  frame_done
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(TAPS);
   localparam logic [CW-1:0] LAST_COEF = CW'(TAPS - 1);
`ifdef FIR_FEEDER_FLUSH_EN
   localparam logic [CW-1:0] LAST_FLUSH = CW'(TAPS - 2);

   typedef enum logic [1:0] {ST_LOAD, ST_STREAM, ST_FLUSH} state_t;
`else
   typedef enum logic [1:0] {ST_LOAD, ST_STREAM} state_t;
`endif

   logic [DATA_WIDTH:0]   mem_q [FIFO_DEPTH];
   logic [AW:0]           wr_ptr_q, rd_ptr_q;
   logic                  full, empty, push, pop;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_last;

   state_t                state_q, state_d;
   logic [CW-1:0]         coef_cnt_q, coef_cnt_d;
   logic                  pending_q, pending_d;
   logic                  enable_q, enable_d;
   logic                  control_q, control_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [DATA_WIDTH-1:0] x_q, x_d;
   logic                  done_q, done_d;
`ifdef FIR_FEEDER_FLUSH_EN
   logic [CW-1:0]         flush_cnt_q, flush_cnt_d;
`endif

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign push    = s_valid && !full;
   assign s_ready = !full;
   assign {rd_last, rd_data} = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {s_last, s_data};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_comb begin
      state_d     = state_q;
      coef_cnt_d  = coef_cnt_q;
      pending_d   = pending_q;
      enable_d    = 1'b0;
      control_d   = control_q;
      b_d         = b_q;
      x_d         = x_q;
      done_d      = 1'b0;
      pop         = 1'b0;
`ifdef FIR_FEEDER_FLUSH_EN
      flush_cnt_d = flush_cnt_q;
`endif
      case (state_q)
         ST_LOAD: begin
            if (!empty && !stall) begin
               pop       = 1'b1;
               enable_d  = 1'b1;
               control_d = 1'b0;
               b_d       = rd_data;
               if (coef_cnt_q == LAST_COEF) begin
                  coef_cnt_d = '0;
                  state_d    = ST_STREAM;
               end else begin
                  coef_cnt_d = coef_cnt_q + CW'(1);
               end
            end
         end
         ST_STREAM: begin
            if (!empty && !stall) begin
               pop       = 1'b1;
               enable_d  = 1'b1;
               control_d = 1'b1;
               x_d       = rd_data;
               if (rd_last) begin
`ifdef FIR_FEEDER_FLUSH_EN
                  state_d     = ST_FLUSH;
                  flush_cnt_d = '0;
`else
                  done_d  = 1'b1;
                  state_d = (pending_q || reload) ? ST_LOAD : ST_STREAM;
`endif
               end
            end
         end
`ifdef FIR_FEEDER_FLUSH_EN
         ST_FLUSH: begin
            if (!stall) begin
               enable_d  = 1'b1;
               control_d = 1'b1;
               x_d       = '0;
               if (flush_cnt_q == LAST_FLUSH) begin
                  flush_cnt_d = '0;
                  done_d      = 1'b1;
                  state_d     = (pending_q || reload) ? ST_LOAD : ST_STREAM;
               end else begin
                  flush_cnt_d = flush_cnt_q + CW'(1);
               end
            end
         end
`endif
         default: state_d = ST_LOAD;
      endcase
      // Any request seen while loading, or consumed by a boundary into LOAD, is already satisfied.
      if (state_q == ST_LOAD || state_d == ST_LOAD) begin
         pending_d = 1'b0;
      end else if (reload) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_LOAD;
         coef_cnt_q  <= '0;
         pending_q   <= 1'b0;
         enable_q    <= 1'b0;
         control_q   <= 1'b0;
         b_q         <= '0;
         x_q         <= '0;
         done_q      <= 1'b0;
`ifdef FIR_FEEDER_FLUSH_EN
         flush_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         coef_cnt_q  <= coef_cnt_d;
         pending_q   <= pending_d;
         enable_q    <= enable_d;
         control_q   <= control_d;
         b_q         <= b_d;
         x_q         <= x_d;
         done_q      <= done_d;
`ifdef FIR_FEEDER_FLUSH_EN
         flush_cnt_q <= flush_cnt_d;
`endif
      end
   end

   assign fir_enable  = enable_q;
   assign fir_control = control_q;
   assign fir_b       = b_q;
   assign fir_x       = x_q;
   assign frame_done  = done_q;

endmodule

// File: tb/tb_fir_feeder.sv
// Bench for fir_feeder (TAPS=4, FIFO_DEPTH=8); follows FIR_FEEDER_FLUSH_EN when defined.
module tb_fir_feeder;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        s_valid = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_last = 1'b0;
   logic        s_ready;
   logic        reload = 1'b0;
   logic        stall = 1'b0;
   logic        fir_enable, fir_control, frame_done;
   logic [31:0] fir_b, fir_x;

   fir_feeder #(.DATA_WIDTH(32), .TAPS(4), .FIFO_DEPTH(8)) dut (
      .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
      .s_ready(s_ready), .reload(reload), .stall(stall), .fir_enable(fir_enable),
      .fir_control(fir_control), .fir_b(fir_b), .fir_x(fir_x), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ctrl;
      logic [31:0] val;
      logic        done;
   } exp_t;

   typedef struct {
      logic        push;
      logic [31:0] data;
      logic        last;
      logic        has_exp;
      logic        ctrl;
      logic [31:0] val;
      logic        done;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[$];
   int   en_cyc[$];
   int   checks = 0;
   int   errors = 0;
   int   en_cnt = 0;
   int   cyc = 0;
   exp_t mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // Scoreboard: every presented word is matched against the oldest expectation.
   always @(negedge clk) begin
      if (reset_n) begin
         if (fir_enable) begin
            en_cnt++;
            en_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_enable: ctrl=%0d b=%0h x=%0h (t=%0t)", fir_control, fir_b, fir_x, $time);
            end else begin
               mon_e = sb.pop_front();
               chk("fir_control", 32'(fir_control), 32'(mon_e.ctrl));
               chk(mon_e.ctrl ? "fir_x" : "fir_b", mon_e.ctrl ? fir_x : fir_b, mon_e.val);
               chk("frame_done", 32'(frame_done), 32'(mon_e.done));
            end
         end else if (frame_done) begin
            checks++;
            errors++;
            $display("FAIL stray_frame_done: got 1 expected 0 without fir_enable (t=%0t)", $time);
         end
      end
   end

   task automatic expect_word(input logic c, input logic [31:0] v, input logic d);
      exp_t e;
      e.ctrl = c; e.val = v; e.done = d;
      sb.push_back(e);
   endtask

   task automatic add(input logic p, input logic [31:0] d, input logic l,
                      input logic he, input logic c, input logic [31:0] v, input logic dn);
      vec_t r;
      r.push = p; r.data = d; r.last = l; r.has_exp = he; r.ctrl = c; r.val = v; r.done = dn;
      tbl.push_back(r);
   endtask

   task automatic coef(input logic [31:0] d);
      add(1'b1, d, 1'b0, 1'b1, 1'b0, d, 1'b0);
   endtask

   task automatic samp(input logic [31:0] d);
      add(1'b1, d, 1'b0, 1'b1, 1'b1, d, 1'b0);
   endtask

   // Last sample of a frame plus the flush words that follow it, if any.
   task automatic last_samp(input logic [31:0] d);
`ifdef FIR_FEEDER_FLUSH_EN
      add(1'b1, d, 1'b1, 1'b1, 1'b1, d, 1'b0);
      add(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0);
      add(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0);
      add(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b1);
`else
      add(1'b1, d, 1'b1, 1'b1, 1'b1, d, 1'b1);
`endif
   endtask

   task automatic send(input logic [31:0] d, input logic l);
      int   t;
      logic acc;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      t = 0;
      do begin
         acc = s_ready;
         @(negedge clk);
         t++;
      end while (!acc && t < 50);
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: word %0h never accepted", d);
      end
   endtask

   task automatic run_table();
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].has_exp) expect_word(tbl[i].ctrl, tbl[i].val, tbl[i].done);
         if (tbl[i].push) send(tbl[i].data, tbl[i].last);
      end
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d expected words never presented, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic chk_outputs_reset(input string tag);
      chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
      chk({tag, "_fir_enable"}, 32'(fir_enable), 32'd0);
      chk({tag, "_fir_control"}, 32'(fir_control), 32'd0);
      chk({tag, "_fir_b"}, fir_b, 32'd0);
      chk({tag, "_fir_x"}, fir_x, 32'd0);
      chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap;
      int n_exp;

      repeat (3) @(negedge clk);
      chk_outputs_reset("reset");
      reset_n = 1'b1;
      @(negedge clk);

      // Coefficient load, streaming samples, one frame end, streaming resumes.
      tbl.delete();
      coef(32'd1); coef(32'd2); coef(32'd3); coef(32'd4);
      samp(32'd10); samp(32'd11);
      last_samp(32'd20);
      samp(32'd21);
      n_exp = 0;
      foreach (tbl[i]) if (tbl[i].has_exp) n_exp++;
      en_cyc.delete();
      run_table();
      drain("load_stream");
      chk("burst_count", 32'(en_cyc.size()), 32'(n_exp));
      if (en_cyc.size() > 0) chk("burst_span", 32'(en_cyc[$] - en_cyc[0]), 32'(en_cyc.size() - 1));

      // Stall with a full FIFO: nothing popped, source held, order kept on release.
      stall = 1'b1;
      snap = en_cnt;
      for (int i = 0; i < 8; i++) begin
         expect_word(1'b1, 32'(100 + i), 1'b0);
         send(32'(100 + i), 1'b0);
      end
      chk("s_ready_full", 32'(s_ready), 32'd0);
      s_valid = 1'b1;
      s_data  = 32'd108;
      repeat (3) @(negedge clk);
      chk("s_ready_held", 32'(s_ready), 32'd0);
      chk("no_enable_in_stall", 32'(en_cnt - snap), 32'd0);
      stall = 1'b0;
      expect_word(1'b1, 32'd108, 1'b0);
      send(32'd108, 1'b0);
      drain("stall");
      chk("stall_release_count", 32'(en_cnt - snap), 32'd9);

      // Reload requested mid-frame takes effect at the next frame boundary.
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      tbl.delete();
      samp(32'd5);
      last_samp(32'd6);
      coef(32'd7); coef(32'd8); coef(32'd9); coef(32'd10);
      samp(32'd30);
      run_table();
      drain("reload");

      // Reset in the middle of a coefficient load discards FIFO and partial count.
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      tbl.delete();
      coef(32'd90); coef(32'd91);
      run_table();
      drain("partial_load");
      stall = 1'b1;
      send(32'd92, 1'b0);
      reset_n = 1'b0;
      #1;
      chk_outputs_reset("midreset");
      @(negedge clk);
      stall = 1'b0;
      reset_n = 1'b1;
      tbl.delete();
      coef(32'd40); coef(32'd41); coef(32'd42); coef(32'd43);
      samp(32'd50);
      run_table();
      drain("after_reset");
      chk("fifo_empty_after", 32'(s_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fir_feeder.md
# fir_feeder

Upstream sequencer for the `Fir` filter. It accepts a single word stream over a valid/ready handshake and buffers it in an internal FIFO. It presents the first `TAPS` words of each configuration as coefficients (`control` = 0, `b`), then every following word as samples (`control` = 1, `x`), with one `enable` pulse per word. Optionally it flushes the filter with zero samples at frame end and reloads coefficients on request.

## Interface
- `DATA_WIDTH`, 32, width of coefficient/sample words.
- `TAPS`, 8, number of coefficients per load; ≥ 2.
- `FIFO_DEPTH`, 8, input FIFO entries; power of 2, ≥ 2.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: input word valid.
- `s_data` in DATA_WIDTH: input word.
- `s_last` in 1: word is the last sample of a frame; ignored on coefficient words.
- `s_ready` out 1: FIFO can accept a word.
- `reload` in 1: one-cycle pulse requesting a coefficient reload.
- `stall` in 1: downstream hold; no FIFO pop while high.
- `fir_enable` out 1: one-cycle strobe per presented word.
- `fir_control` out 1: 0 = coefficient word, 1 = sample word.
- `fir_b` out DATA_WIDTH: current coefficient; holds between loads.
- `fir_x` out DATA_WIDTH: current sample; holds between samples.
- `frame_done` out 1: one-cycle pulse at frame completion.

## Operation
- FIFO entries are DATA_WIDTH+1 bits wide (data plus last). A word is pushed when `s_valid & s_ready`.
- `s_ready` = !full. A push and a pop in the same cycle are both honoured.
- FSM states:
  - LOAD: pops while FIFO non-empty & !stall. Each pop drives `fir_control`=0, `fir_b`=data and increments `coef_cnt`. On the `TAPS`-th pop: `coef_cnt`←0, state → STREAM.
  - STREAM: pops while FIFO non-empty & !stall and drives `fir_control`=1, `fir_x`=data.
    - Popped word with last=1 → FLUSH (macro on), otherwise `frame_done` pulses.
    - At that frame boundary, if `reload_pending` is set, the next state is LOAD instead.
  - FLUSH: while !stall, emits `TAPS`-1 words with `fir_x`=0, `fir_control`=1, without popping. It then pulses `frame_done` and goes to LOAD if `reload_pending`, else STREAM.
- `reload` sets `reload_pending`. The flag is cleared when LOAD is entered. A reload in LOAD is a no-op, and the flag is cleared.
- A `reload` pulse in the same cycle as a frame boundary takes effect at that boundary.
- `fir_enable` = 1 exactly in the cycle after each pop or flush emission.

## Timing
- Reset values: state LOAD, FIFO empty, `coef_cnt`=0, `reload_pending`=0, `s_ready`=1.
- All other outputs reset to 0.
- All outputs are registered.
- Latency: a word accepted at edge N is presented with `fir_enable`=1 after edge N+1 at the earliest.
- Throughput: one word per cycle.
- `stall` sampled at edge N blocks the pop/emission at N. `fir_enable` is 0 after N.
- Full FIFO: `s_ready`=0 and words are held by the source; nothing is dropped.
- Empty FIFO in LOAD/STREAM: `fir_enable`=0 and outputs hold.
- Pointers wrap modulo `FIFO_DEPTH`. Occupancy is tracked with an extra pointer bit.
- `reset_n` low mid-operation clears immediately: FIFO contents discarded, partial coefficient count lost. The next `TAPS` words are coefficients.

## Configuration
- `FIR_FEEDER_FLUSH_EN` defined: FLUSH state present, with `TAPS`-1 zero samples after each last sample. `frame_done` pulses after the final flush word.
- Not defined: no FLUSH state. `frame_done` pulses in the cycle `fir_enable` presents the last sample, and the reload decision is taken there.

## Test plan
- `TAPS`=4, `FIFO_DEPTH`=8; push 1,2,3,4,10,11 → four enables with `fir_control`=0, `fir_b`=1,2,3,4, then `fir_control`=1, `fir_x`=10,11 on consecutive cycles.
- After load, hold `stall`=1 and offer 9 words → `s_ready` falls after 8 accepted, no `fir_enable`. Release → 8 enables in order, then the 9th.
- With macro, sample 20 with `s_last` → `fir_x`=20, then three enables with `fir_x`=0, `frame_done` after the third, then streaming resumes. Without macro → `frame_done` coincides with `fir_x`=20.
- `reload` pulse mid-frame, then samples 5,6(last), 7,8,9,10 → 5,6 as samples (plus flush if enabled), then `fir_b`=7,8,9,10 with `fir_control`=0.
- `reset_n` low after 2 of 4 coefficients, then push 40,41,42,43,50 → all outputs 0 during reset, `fir_b`=40..43, then `fir_x`=50.
